ps2_key_tracker: RTL and testbench

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

---
 rtl/ps2_key_tracker.sv | 173 +++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver that decodes scan-code set 2 make/break sequences
// into a four-slot table of currently held (non-extended) keys.
module ps2_key_tracker #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode1,
  output logic [7:0] keycode2,
  output logic [7:0] keycode3,
  output logic [7:0] keycode4,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BRK = 2'd1, EXT = 2'd2, EXT_BRK = 2'd3} state_t;

  // Odd parity holds when data bits plus the parity bit contain an odd count of ones.
  function automatic logic odd_parity_ok(input logic [8:0] v);
    return ^v;
  endfunction

  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  logic          clk_meta, clk_sync, clk_prev;
  logic          data_meta, data_sync;
  logic          fall;
  logic          timeout;
  logic          frame_good;
  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] idle_cnt;
  state_t        state;
  logic [7:0]    slot [4];
  logic          present;
  logic          has_empty;
  logic [1:0]    empty_idx;

  // Two-flop synchronizers plus one history flop for falling-edge detection; idle bus is high.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  assign fall    = clk_prev & ~clk_sync;
  assign timeout = (bit_cnt != 4'd0) && !fall && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  // shreg holds start..parity; the stop bit is the sample arriving right now.
  assign frame_good = ~shreg[0] & data_sync & odd_parity_ok(shreg[9:1]);

  // Frame receiver: shifts bits in LSB first and judges the frame on the stop-bit sample.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shreg      <= 10'd0;
      bit_cnt    <= 4'd0;
      idle_cnt   <= '0;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (frame_good) begin
            rx_byte    <= shreg[8:1];
            byte_valid <= 1'b1;
          end else begin
            frame_err  <= 1'b1;
          end
        end else begin
          shreg   <= {data_sync, shreg[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (timeout) begin
          bit_cnt   <= 4'd0;
          idle_cnt  <= '0;
          frame_err <= 1'b1;
        end else begin
          idle_cnt  <= idle_cnt + TW'(1);
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  // Table lookup for the byte just received: membership and lowest free slot.
  always_comb begin
    present   = (slot[0] == rx_byte) || (slot[1] == rx_byte) ||
                (slot[2] == rx_byte) || (slot[3] == rx_byte);
    has_empty = (slot[0] == 8'h00) || (slot[1] == 8'h00) ||
                (slot[2] == 8'h00) || (slot[3] == 8'h00);
    if (slot[0] == 8'h00) begin
      empty_idx = 2'd0;
    end else if (slot[1] == 8'h00) begin
      empty_idx = 2'd1;
    end else if (slot[2] == 8'h00) begin
      empty_idx = 2'd2;
    end else begin
      empty_idx = 2'd3;
    end
  end

  // Decode FSM and key table, stepped once per received byte.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      for (int i = 0; i < 4; i++) slot[i] <= 8'h00;
    end else if (timeout) begin
      state <= IDLE;
    end else if (byte_valid) begin
      case (state)
        IDLE: begin
          if (rx_byte == 8'hF0) begin
            state <= BRK;
          end else if (rx_byte == 8'hE0) begin
            state <= EXT;
          end else if (!is_ignored(rx_byte) && !present && has_empty) begin
            slot[empty_idx] <= rx_byte;
            state <= IDLE;
          end else begin
            state <= IDLE;
          end
        end
        BRK: begin
          for (int i = 0; i < 4; i++) begin
            if (slot[i] == rx_byte) slot[i] <= 8'h00;
          end
          state <= IDLE;
        end
        EXT: begin
          state <= (rx_byte == 8'hF0) ? EXT_BRK : IDLE;
        end
        EXT_BRK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign keycode1 = slot[0];
  assign keycode2 = slot[1];
  assign keycode3 = slot[2];
  assign keycode4 = slot[3];

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench: directed scenarios plus random byte streams compared
// against a set-based reference model of held keys.
module tb_ps2_key_tracker;
  localparam int TO   = 200;
  localparam int HALF = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode1, keycode2, keycode3, keycode4, rx_byte;
  logic       byte_valid, frame_err;

  ps2_key_tracker #(.TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(clk), .sys_rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode1(keycode1), .keycode2(keycode2), .keycode3(keycode3), .keycode4(keycode4),
    .rx_byte(rx_byte), .byte_valid(byte_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int bv_count = 0;
  int fe_count = 0;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] kc1_at_bv = 8'h00;
  logic [7:0] kc1_after_bv = 8'h00;
  logic       bv_seen_prev = 1'b0;

  // Reference model: held keys and pending prefix flags.
  logic [7:0] m_slot [4];
  bit         m_brk, m_ext;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (bv_seen_prev) kc1_after_bv = keycode1;
    bv_seen_prev = byte_valid;
    if (byte_valid) begin
      bv_count++;
      last_rx = rx_byte;
      kc1_at_bv = keycode1;
    end
    if (frame_err) fe_count++;
  end

  function automatic bit ignored(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_slot[i] = 8'h00;
    m_brk = 0;
    m_ext = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit held;
    bit placed;
    if (m_ext) begin
      if (b == 8'hF0 && !m_brk) m_brk = 1;
      else begin m_ext = 0; m_brk = 0; end
    end else if (m_brk) begin
      for (int i = 0; i < 4; i++) if (m_slot[i] == b) m_slot[i] = 8'h00;
      m_brk = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (!ignored(b)) begin
      held = 0;
      for (int i = 0; i < 4; i++) if (m_slot[i] == b) held = 1;
      placed = 0;
      for (int i = 0; i < 4; i++)
        if (!held && !placed && m_slot[i] == 8'h00) begin m_slot[i] = b; placed = 1; end
    end
  endtask

  task automatic check_table(input string tag);
    check_eq({tag, ".kc1"}, {24'd0, keycode1}, {24'd0, m_slot[0]});
    check_eq({tag, ".kc2"}, {24'd0, keycode2}, {24'd0, m_slot[1]});
    check_eq({tag, ".kc3"}, {24'd0, keycode3}, {24'd0, m_slot[2]});
    check_eq({tag, ".kc4"}, {24'd0, keycode4}, {24'd0, m_slot[3]});
  endtask

  task automatic send_bits(input logic [7:0] b, input bit flip_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
  endtask

  // Sends one frame, steps the model, and checks pulses and the table.
  task automatic send_byte(input string tag, input logic [7:0] b, input bit bad);
    int bv0, fe0;
    bv0 = bv_count;
    fe0 = fe_count;
    send_bits(b, bad, 11);
    #1;
    if (bad) begin
      check_eq({tag, ".err"}, fe_count, fe0 + 1);
      check_eq({tag, ".nobv"}, bv_count, bv0);
    end else begin
      model_byte(b);
      check_eq({tag, ".bv"}, bv_count, bv0 + 1);
      check_eq({tag, ".rx"}, {24'd0, last_rx}, {24'd0, b});
      check_eq({tag, ".noerr"}, fe_count, fe0);
    end
    check_table(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pool [10];
    int bv0, fe0, waited;
    logic [7:0] b;
    pool = '{8'h1D, 8'h1B, 8'h44, 8'h4B, 8'h23, 8'h2B, 8'hF0, 8'hE0, 8'hAA, 8'h75};
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    check_table("reset");
    check_eq("reset.rx", {24'd0, rx_byte}, 32'd0);
    check_eq("reset.pulses", {30'd0, byte_valid, frame_err}, 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // First key: byte_valid pulse precedes the table update by one cycle.
    send_byte("k1d", 8'h1D, 0);
    check_eq("k1d.kc_at_bv", {24'd0, kc1_at_bv}, 32'h00);
    check_eq("k1d.kc_after", {24'd0, kc1_after_bv}, 32'h1D);

    send_byte("k1b", 8'h1B, 0);
    send_byte("k44", 8'h44, 0);
    send_byte("k4b", 8'h4B, 0);
    send_byte("rep", 8'h1D, 0);
    send_byte("full", 8'h23, 0);
    send_byte("brkp", 8'hF0, 0);
    send_byte("brk1b", 8'h1B, 0);
    check_eq("brk.kc2", {24'd0, keycode2}, 32'h00);
    send_byte("fill", 8'h23, 0);
    check_eq("fill.kc2", {24'd0, keycode2}, 32'h23);

    // Parity error, then a good break still works.
    send_byte("par", 8'h1D, 1);
    send_byte("par_f0", 8'hF0, 0);
    send_byte("par_1d", 8'h1D, 0);

    // Extended make/break leave the table alone.
    send_byte("e0a", 8'hE0, 0);
    send_byte("e75", 8'h75, 0);
    send_byte("e0b", 8'hE0, 0);
    send_byte("ef0", 8'hF0, 0);
    send_byte("ebrk75", 8'h75, 0);
    send_byte("after_ext", 8'h1D, 0);

    // Timeout after a break prefix: FSM must fall back to IDLE.
    send_byte("to_f0", 8'hF0, 0);
    fe0 = fe_count;
    send_bits(8'h44, 0, 5);
    waited = 0;
    while (fe_count == fe0 && waited < TO + 100) begin
      @(posedge clk);
      waited++;
    end
    #1;
    check_eq("timeout.err", fe_count, fe0 + 1);
    m_brk = 0;
    m_ext = 0;
    send_byte("to_44", 8'h44, 0);

    // Reset in the middle of a frame.
    bv0 = bv_count;
    fe0 = fe_count;
    send_bits(8'h2B, 0, 6);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (TO + 60) @(posedge clk);
    #1;
    check_eq("mrst.nobv", bv_count, bv0);
    check_eq("mrst.noerr", fe_count, fe0);
    check_eq("mrst.rx", {24'd0, rx_byte}, 32'd0);
    check_table("mrst");
    send_byte("mrst_1d", 8'h1D, 0);

    // Randomized byte stream with occasional parity errors.
    for (int n = 0; n < 60; n++) begin
      b = pool[$urandom_range(9, 0)];
      if ($urandom_range(15, 0) == 0) b = 8'($urandom_range(255, 0));
      send_byte("rnd", b, ($urandom_range(9, 0) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
